// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and default sizing for the mux scan controller
//                and the downstream N:1 mux it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Default channel count of the scanned mux and its select width
    localparam int MUX_N     = 16;
    localparam int MUX_SEL_W = $clog2(MUX_N);

    // Scan controller states; IDLE is the reset state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } scan_state_e;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_next_channel.sv
`default_nettype none
// ============================================================================
//  Module      : mux_next_channel
//  Description : Combinational search for the lowest set mask bit at or above
//                a start index. Used for both the first-channel and the
//                next-channel lookups of the scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_next_channel
    import mux_pkg::*;
#(
    parameter int N     = MUX_N,
    parameter int IDX_W = MUX_SEL_W
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W:0]   start_idx,   // one extra bit so "past the last channel" is representable
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan downward so the last hit written is the lowest qualifying index
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start_idx))) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule : mux_next_channel
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Steps the select of an external N:1 mux through every
//                enabled channel, one per cycle, capturing the mux output
//                into a result vector. Supports abort and empty masks.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int N = MUX_N,
    parameter int m = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] mask,
    input  logic         mux_bit,
    output logic [m-1:0] select,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         result_valid
);

    scan_state_e  state_q, state_d;
    logic [m-1:0] select_q, select_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] result_q, result_d;
    logic         result_valid_q, result_valid_d;

    logic [N-1:0] lookup_mask;
    logic [m:0]   lookup_start;
    logic [m-1:0] lookup_idx;
    logic         lookup_found;

    // Shared lookup: in IDLE find the first channel of the incoming mask,
    // otherwise find the channel after the one currently selected
    always_comb begin
        if (state_q == IDLE) begin
            lookup_mask  = mask;
            lookup_start = '0;
        end else begin
            lookup_mask  = mask_q;
            lookup_start = {1'b0, select_q} + (m+1)'(1);
        end
    end

    mux_next_channel #(
        .N     (N),
        .IDX_W (m)
    ) u_next_channel (
        .mask      (lookup_mask),
        .start_idx (lookup_start),
        .idx       (lookup_idx),
        .found     (lookup_found)
    );

    // State register: all scan state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            select_q       <= '0;
            mask_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            select_q       <= select_d;
            mask_q         <= mask_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state logic; abort outranks both start and scan progress
    always_comb begin
        state_d        = state_q;
        select_d       = select_q;
        mask_d         = mask_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mask_d   = mask;
                    result_d = '0;
                    if (|mask) begin
                        select_d       = lookup_idx;
                        result_valid_d = 1'b0;
                        state_d        = SCAN;
                    end else begin
                        // Empty mask: nothing to sample, finish with select untouched
                        result_valid_d = 1'b1;
                        state_d        = FINISH;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    result_d[select_q] = mux_bit;
                    if (lookup_found) begin
                        select_d = lookup_idx;
                    end else begin
                        // Highest enabled channel just sampled; no wrap-around
                        result_valid_d = 1'b1;
                        state_d        = FINISH;
                    end
                end
            end
            FINISH: begin
                if (abort) begin
                    result_valid_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy         = (state_q == SCAN) || (state_q == FINISH);
        done         = (state_q == FINISH);
        select       = select_q;
        result       = result_q;
        result_valid = result_valid_q;
    end

endmodule : mux_scan_ctrl
`default_nettype wire
